// File: rtl/dm_access_arbiter_if.sv
// Bus bundle between the data-memory arbiter (slave) and its two requesters
// plus the memory itself (master side).
interface dm_access_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_in;
    logic [DATA_W-1:0] dm_out;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  dm_read, dm_write, dm_address, dm_in,
        output dm_out
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output dm_read, dm_write, dm_address, dm_in,
        input  dm_out
    );
endinterface

// File: rtl/dm_access_arbiter.sv
// Single-port data-memory arbiter: CPU-first priority with a DMA starvation guard.
// Optional DMA burst lock enabled by defining DM_ARB_DMA_LOCK_EN.
module dm_access_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic clk,
    input logic rst,
`ifdef DM_ARB_DMA_LOCK_EN
    input logic dma_lock,
`endif
    dm_access_arbiter_if.slave bus
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        r_starve_cnt;
    logic              r_cpu_rvalid;
    logic              r_dma_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;

    logic              w_starved;
    logic              w_dma_locked;
    logic              w_cpu_win;
    logic              w_dma_win;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

`ifdef DM_ARB_DMA_LOCK_EN
    logic r_owner_dma;

    // Lock holds only while DMA keeps both its request and the lock asserted.
    assign w_dma_locked = r_owner_dma & bus.dma_req & dma_lock;

    always_ff @(posedge clk) begin
        if (rst) r_owner_dma <= 1'b0;
        else     r_owner_dma <= w_dma_win & dma_lock;
    end
`else
    assign w_dma_locked = 1'b0;
`endif

    assign w_starved = (r_starve_cnt == STARVE_LIM);

    always_comb begin
        w_cpu_win = ~rst & bus.cpu_req & ~(bus.dma_req & (w_starved | w_dma_locked));
        w_dma_win = ~rst & bus.dma_req & ~w_cpu_win;
        w_win_we  = 1'b0;
        w_addr    = '0;
        w_wdata   = '0;
        if (w_cpu_win) begin
            w_win_we = bus.cpu_we;
            w_addr   = bus.cpu_addr;
            w_wdata  = bus.cpu_wdata;
        end else if (w_dma_win) begin
            w_win_we = bus.dma_we;
            w_addr   = bus.dma_addr;
            w_wdata  = bus.dma_wdata;
        end
    end

    assign bus.cpu_gnt    = w_cpu_win;
    assign bus.dma_gnt    = w_dma_win;
    assign bus.dm_read    = (w_cpu_win | w_dma_win) & ~w_win_we;
    assign bus.dm_write   = (w_cpu_win | w_dma_win) & w_win_we;
    assign bus.dm_address = w_addr;
    assign bus.dm_in      = w_wdata;

    // A load granted just before reset must not surface while reset is held.
    assign bus.cpu_rvalid = r_cpu_rvalid & ~rst;
    assign bus.dma_rvalid = r_dma_rvalid & ~rst;
    assign bus.cpu_rdata  = r_cpu_rdata;
    assign bus.dma_rdata  = r_dma_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dma_rvalid <= 1'b0;
        end else begin
            r_cpu_rvalid <= w_cpu_win & ~bus.cpu_we;
            r_dma_rvalid <= w_dma_win & ~bus.dma_we;
            if (!bus.dma_req || w_dma_win)
                r_starve_cnt <= '0;
            else if (r_starve_cnt != STARVE_LIM)
                r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Read data registers: captured from the combinational memory output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            if (w_cpu_win && !bus.cpu_we) r_cpu_rdata <= bus.dm_out;
            if (w_dma_win && !bus.dma_we) r_dma_rdata <= bus.dm_out;
        end
    end
endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter with a behavioural memory and
// arbitration reference model.
module tb_dm_access_arbiter;
    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dm_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DM_ARB_DMA_LOCK_EN
    logic dma_lock;
`endif

    dm_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef DM_ARB_DMA_LOCK_EN
        .dma_lock (dma_lock),
`endif
        .bus      (bus)
    );

    // Data memory: combinational read, synchronous write.
    logic [DATA_W-1:0] mem     [0:255];
    logic [DATA_W-1:0] ref_mem [0:255];

    function automatic logic [DATA_W-1:0] seed(input int i);
        return 32'h1000_0000 ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    assign bus.dm_out = mem[bus.dm_address[7:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
        end else if (bus.dm_write) begin
            mem[bus.dm_address[7:0]] <= bus.dm_in;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
`ifdef DM_ARB_DMA_LOCK_EN
        dma_lock = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 16'h0002; bus.dma_wdata = 32'h1234_5678;
        tick();
        tick();
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b0) begin errors++; $display("FAIL reset_cpu_gnt got=%b exp=0", bus.cpu_gnt); end
        checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_dma_gnt got=%b exp=0", bus.dma_gnt); end
        checks++; if (bus.dm_read !== 1'b0) begin errors++; $display("FAIL reset_dm_read got=%b exp=0", bus.dm_read); end
        checks++; if (bus.dm_write !== 1'b0) begin errors++; $display("FAIL reset_dm_write got=%b exp=0", bus.dm_write); end
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid got=%b exp=0", bus.cpu_rvalid); end
        checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dma_rvalid got=%b exp=0", bus.dma_rvalid); end
        checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got=%h exp=0", bus.cpu_rdata); end
        checks++; if (bus.dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_dma_rdata got=%h exp=0", bus.dma_rdata); end
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b0;
    endtask

    task automatic test_store_load();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt got=%b exp=1", bus.cpu_gnt); end
        checks++; if (bus.dm_write !== 1'b1) begin errors++; $display("FAIL store_dm_write got=%b exp=1", bus.dm_write); end
        checks++; if (bus.dm_address !== 16'h0010) begin errors++; $display("FAIL store_addr got=%h exp=0010", bus.dm_address); end
        checks++; if (bus.dm_in !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_data got=%h exp=deadbeef", bus.dm_in); end
        ref_mem[16] = 32'hDEAD_BEEF;
        tick();
        bus.cpu_we = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL load_gnt got=%b exp=1", bus.cpu_gnt); end
        checks++; if (bus.dm_read !== 1'b1) begin errors++; $display("FAIL load_dm_read got=%b exp=1", bus.dm_read); end
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL store_rvalid got=%b exp=0", bus.cpu_rvalid); end
        tick();
        drive_idle();
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b1) begin errors++; $display("FAIL load_rvalid got=%b exp=1", bus.cpu_rvalid); end
        checks++; if (bus.cpu_rdata !== ref_mem[16]) begin errors++; $display("FAIL load_rdata got=%h exp=%h", bus.cpu_rdata, ref_mem[16]); end
        tick();
        @(negedge clk);
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL rvalid_single got=%b exp=0", bus.cpu_rvalid); end
        checks++; if (bus.cpu_rdata !== ref_mem[16]) begin errors++; $display("FAIL rdata_hold got=%h exp=%h", bus.cpu_rdata, ref_mem[16]); end
        tick();
    endtask

    task automatic test_idle();
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if ({bus.cpu_gnt, bus.dma_gnt, bus.dm_read, bus.dm_write} !== 4'b0000) begin
                errors++; $display("FAIL idle_ctrl cycle=%0d got=%b exp=0000", c, {bus.cpu_gnt, bus.dma_gnt, bus.dm_read, bus.dm_write}); end
            checks++; if (bus.dm_address !== 16'h0 || bus.dm_in !== 32'h0) begin
                errors++; $display("FAIL idle_bus cycle=%0d got=%h/%h exp=0/0", c, bus.dm_address, bus.dm_in); end
            checks++; if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
                errors++; $display("FAIL idle_rvalid cycle=%0d got=%b%b exp=00", c, bus.cpu_rvalid, bus.dma_rvalid); end
            tick();
        end
    endtask

    task automatic test_isolation();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0003;
        @(negedge clk);
        checks++; if (bus.dma_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0) begin
            errors++; $display("FAIL iso_gnt got=cpu%b dma%b exp=cpu0 dma1", bus.cpu_gnt, bus.dma_gnt); end
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL iso_cpu_rvalid0 got=%b exp=0", bus.cpu_rvalid); end
        tick();
        drive_idle();
        @(negedge clk);
        checks++; if (bus.dma_rvalid !== 1'b1) begin errors++; $display("FAIL iso_dma_rvalid got=%b exp=1", bus.dma_rvalid); end
        checks++; if (bus.dma_rdata !== ref_mem[3]) begin errors++; $display("FAIL iso_dma_rdata got=%h exp=%h", bus.dma_rdata, ref_mem[3]); end
        checks++; if (bus.cpu_rvalid !== 1'b0) begin errors++; $display("FAIL iso_cpu_rvalid1 got=%b exp=0", bus.cpu_rvalid); end
        tick();
    endtask

    task automatic test_starve();
        bit prev_dma = 1'b0;
        bit exp_dma;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0020;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0021;
        for (int c = 0; c < 10; c++) begin
            exp_dma = ((c % (STARVE_MAX + 1)) == STARVE_MAX);
            @(negedge clk);
            checks++; if (bus.cpu_gnt !== !exp_dma || bus.dma_gnt !== exp_dma) begin
                errors++; $display("FAIL starve_gnt cycle=%0d got=cpu%b dma%b exp=cpu%b dma%b", c, bus.cpu_gnt, bus.dma_gnt, !exp_dma, exp_dma); end
            if (c > 0) begin
                checks++; if (bus.dma_rvalid !== prev_dma || bus.cpu_rvalid !== !prev_dma) begin
                    errors++; $display("FAIL starve_rvalid cycle=%0d got=cpu%b dma%b exp=cpu%b dma%b", c, bus.cpu_rvalid, bus.dma_rvalid, !prev_dma, prev_dma); end
            end
            if (prev_dma) begin
                checks++; if (bus.dma_rdata !== ref_mem[33]) begin
                    errors++; $display("FAIL starve_dma_rdata cycle=%0d got=%h exp=%h", c, bus.dma_rdata, ref_mem[33]); end
            end
            prev_dma = exp_dma;
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0021;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.cpu_gnt !== 1'b1) begin errors++; $display("FAIL rmid_pre_gnt cycle=%0d got=%b exp=1", c, bus.cpu_gnt); end
            tick();
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if ({bus.cpu_gnt, bus.dma_gnt, bus.dm_read, bus.dm_write} !== 4'b0000) begin
                errors++; $display("FAIL rmid_ctrl cycle=%0d got=%b exp=0000", c, {bus.cpu_gnt, bus.dma_gnt, bus.dm_read, bus.dm_write}); end
            checks++; if (bus.cpu_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin
                errors++; $display("FAIL rmid_rvalid cycle=%0d got=%b%b exp=00", c, bus.cpu_rvalid, bus.dma_rvalid); end
            tick();
        end
        rst = 1'b0;
        // Starvation count was cleared, so the CPU wins STARVE_MAX times again.
        for (int c = 0; c <= STARVE_MAX; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++; if (bus.cpu_rdata !== 32'h0) begin errors++; $display("FAIL rmid_rdata_clr got=%h exp=0", bus.cpu_rdata); end
            end
            checks++; if (bus.dma_gnt !== (c == STARVE_MAX) || bus.cpu_gnt !== (c != STARVE_MAX)) begin
                errors++; $display("FAIL rmid_post_gnt cycle=%0d got=cpu%b dma%b exp=dma%b", c, bus.cpu_gnt, bus.dma_gnt, c == STARVE_MAX); end
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        bit                c_pend = 0, d_pend = 0, c_we = 0, d_we = 0;
        logic [ADDR_W-1:0] c_addr = '0, d_addr = '0, exp_addr;
        logic [DATA_W-1:0] c_wd = '0, d_wd = '0, erd_c = '0, erd_d = '0;
        bit                erv_c = 0, erv_d = 0, exp_c, exp_d, exp_rd, exp_wr;
        int                dma_wait = 0;
        for (int n = 0; n < 400; n++) begin
            if (!c_pend && $urandom_range(0, 9) < 6) begin
                c_pend = 1; c_we = 1'($urandom_range(0, 1)); c_addr = 16'($urandom_range(0, 15)); c_wd = $urandom;
            end
            if (!d_pend && $urandom_range(0, 9) < 6) begin
                d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = 16'($urandom_range(0, 15)); d_wd = $urandom;
            end
            bus.cpu_req = c_pend; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wd;
            bus.dma_req = d_pend; bus.dma_we = d_we; bus.dma_addr = d_addr; bus.dma_wdata = d_wd;
            @(negedge clk);
            exp_c    = c_pend && !(d_pend && dma_wait >= STARVE_MAX);
            exp_d    = d_pend && !exp_c;
            exp_rd   = (exp_c && !c_we) || (exp_d && !d_we);
            exp_wr   = (exp_c && c_we) || (exp_d && d_we);
            exp_addr = exp_c ? c_addr : (exp_d ? d_addr : '0);
            checks++; if (bus.cpu_gnt !== exp_c || bus.dma_gnt !== exp_d) begin
                errors++; $display("FAIL rand_gnt n=%0d got=cpu%b dma%b exp=cpu%b dma%b", n, bus.cpu_gnt, bus.dma_gnt, exp_c, exp_d); end
            checks++; if (bus.dm_read !== exp_rd || bus.dm_write !== exp_wr || bus.dm_address !== exp_addr) begin
                errors++; $display("FAIL rand_bus n=%0d got=r%b w%b a%h exp=r%b w%b a%h", n, bus.dm_read, bus.dm_write, bus.dm_address, exp_rd, exp_wr, exp_addr); end
            checks++; if (bus.cpu_rvalid !== erv_c || (erv_c && bus.cpu_rdata !== erd_c)) begin
                errors++; $display("FAIL rand_cpu_read n=%0d got=v%b d%h exp=v%b d%h", n, bus.cpu_rvalid, bus.cpu_rdata, erv_c, erd_c); end
            checks++; if (bus.dma_rvalid !== erv_d || (erv_d && bus.dma_rdata !== erd_d)) begin
                errors++; $display("FAIL rand_dma_read n=%0d got=v%b d%h exp=v%b d%h", n, bus.dma_rvalid, bus.dma_rdata, erv_d, erd_d); end
            erv_c = exp_c && !c_we;
            erv_d = exp_d && !d_we;
            if (erv_c) erd_c = ref_mem[c_addr[7:0]];
            if (erv_d) erd_d = ref_mem[d_addr[7:0]];
            if (exp_c && c_we) ref_mem[c_addr[7:0]] = c_wd;
            if (exp_d && d_we) ref_mem[d_addr[7:0]] = d_wd;
            dma_wait = (d_pend && !exp_d) ? dma_wait + 1 : 0;
            if (exp_c) c_pend = 0;
            if (exp_d) d_pend = 0;
            tick();
        end
        drive_idle();
        tick();
    endtask

`ifdef DM_ARB_DMA_LOCK_EN
    task automatic test_lock();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 16'h0005; dma_lock = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (bus.dma_gnt !== 1'b1 || bus.cpu_gnt !== 1'b0) begin
                errors++; $display("FAIL lock_hold cycle=%0d got=cpu%b dma%b exp=cpu0 dma1", c, bus.cpu_gnt, bus.dma_gnt); end
            tick();
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0006;
        end
        dma_lock = 1'b0;
        @(negedge clk);
        checks++; if (bus.cpu_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin
            errors++; $display("FAIL lock_release got=cpu%b dma%b exp=cpu1 dma0", bus.cpu_gnt, bus.dma_gnt); end
        tick();
        drive_idle();
        tick();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        mem_init = 1'b1;
        drive_idle();
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
        tick();
        mem_init = 1'b0;
        test_reset();
        test_store_load();
        test_idle();
        test_isolation();
        test_starve();
        test_reset_mid();
        test_random();
`ifdef DM_ARB_DMA_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
